train_dispatch_ctrl: RTL

Scheduler for the single dead-end station track, which behaves as a LIFO stack. Trains arrive in fixed order 1..N; the block receives a requested departure order. It issues the exact ARRIVE/DEPART command sequence to the track actuator, one command per handshake. When no legal sequence exists, it aborts with a failure result. It sits between the order-entry interface and the track actuator.

---
 rtl/train_dispatch_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/train_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : train_dispatch_ctrl
// Purpose  : Dispatch scheduler for a single dead-end (LIFO) station track.
//            Trains arrive in order 1..N. Given the requested departure
//            order, the block emits the exact ARRIVE/DEPART command stream,
//            one command per valid/ready handshake. If no legal sequence
//            exists, it aborts with result = 0.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid, data      - departure order, one entry per beat,
//                                  first-departing train first
//            cmd_ready           - actuator accepts the current command
//            cmd_valid/op/id     - command (op 1 = ARRIVE/push, 0 = DEPART/pop)
//            done, result        - one-cycle completion pulse and outcome
//            occ (optional)      - registered track occupancy (stack depth)
// Options  : `define TRAIN_OCC_OUT_EN adds the occ output port.
// Revision : 1.0 - initial release
// ============================================================================
module train_dispatch_ctrl #(
    parameter int MAX_TRAINS = 10,
    parameter int ID_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [ID_W-1:0] data,
    input  logic            cmd_ready,
    output logic            cmd_valid,
    output logic            cmd_op,
    output logic [ID_W-1:0] cmd_id,
    output logic            done,
    output logic            result
`ifdef TRAIN_OCC_OUT_EN
    ,
    output logic [ID_W-1:0] occ
`endif
);

    localparam int c_CNT_W = $clog2(MAX_TRAINS + 1);
    localparam int c_IDX_W = (MAX_TRAINS > 1) ? $clog2(MAX_TRAINS) : 1;
    // Compare width wide enough for both train ids and counts, plus one bit
    // so next_arr can reach N+1 without wrapping.
    localparam int c_CMP_W = ((ID_W > c_CNT_W) ? ID_W : c_CNT_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_order [MAX_TRAINS];
    logic [ID_W-1:0]      r_stack [MAX_TRAINS];
    logic [c_CNT_W-1:0]   r_n;
    logic [c_CNT_W-1:0]   r_k;
    logic [c_CNT_W-1:0]   r_sp;
    logic [c_CMP_W-1:0]   r_next_arr;
    logic                 r_ovf;
    logic                 r_done;
    logic                 r_result;

    logic                 w_run;
    logic [ID_W-1:0]      w_target;
    logic [c_CMP_W-1:0]   w_target_x;
    logic [c_CMP_W-1:0]   w_n_x;
    logic [c_CNT_W-1:0]   w_sp_m1;
    logic [ID_W-1:0]      w_top;
    logic                 w_illegal;
    logic                 w_depart;
    logic                 w_arrive;
    logic                 w_fail;
    logic                 w_fire;
    logic                 w_last;

    // ------------------------------------------------------------------
    // Decision logic: purely a function of registered state, so command
    // outputs never depend combinationally on cmd_ready and stay stable
    // while the actuator stalls.
    // ------------------------------------------------------------------
    assign w_run      = (r_state == ST_RUN);
    assign w_target   = r_order[r_k[c_IDX_W-1:0]];
    assign w_target_x = {{(c_CMP_W-ID_W){1'b0}}, w_target};
    assign w_n_x      = {{(c_CMP_W-c_CNT_W){1'b0}}, r_n};
    assign w_sp_m1    = r_sp - c_CNT_W'(1);
    assign w_top      = r_stack[w_sp_m1[c_IDX_W-1:0]];

    assign w_illegal  = r_ovf || (w_target == '0) || (w_target_x > w_n_x);
    assign w_depart   = !w_illegal && (r_sp != '0) && (w_top == w_target);
    // A duplicate entry lands here as "not on top and already arrived",
    // so it falls through to the fail case.
    assign w_arrive   = !w_illegal && !w_depart && (r_next_arr <= w_target_x);
    assign w_fail     = w_run && !(w_depart || w_arrive);
    assign w_fire     = cmd_valid && cmd_ready;
    assign w_last     = (r_k == (r_n - c_CNT_W'(1)));

    assign cmd_valid  = w_run && (w_depart || w_arrive);
    assign cmd_op     = w_run && w_arrive;
    assign cmd_id     = !cmd_valid ? '0 :
                        (w_depart ? w_target : r_next_arr[ID_W-1:0]);

    assign done       = r_done;
    assign result     = r_result;

`ifdef TRAIN_OCC_OUT_EN
    assign occ        = ID_W'(r_sp);
`endif

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            for (int i = 0; i < MAX_TRAINS; i++) begin
                r_order[i] <= '0;
                r_stack[i] <= '0;
            end
            r_n        <= '0;
            r_k        <= '0;
            r_sp       <= '0;
            r_next_arr <= c_CMP_W'(1);
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_order[0] <= data;
                        r_n        <= c_CNT_W'(1);
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (in_valid) begin
                        // Beats beyond capacity are dropped; the flag forces
                        // an immediate failure once RUN starts.
                        if (r_n == c_CNT_W'(MAX_TRAINS)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_order[r_n[c_IDX_W-1:0]] <= data;
                            r_n                       <= r_n + c_CNT_W'(1);
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (w_fail) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= 1'b0;
                    end else if (w_fire) begin
                        if (w_depart) begin
                            r_sp <= w_sp_m1;
                            if (w_last) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_result <= 1'b1;
                            end else begin
                                r_k <= r_k + c_CNT_W'(1);
                            end
                        end else begin
                            r_stack[r_sp[c_IDX_W-1:0]] <= r_next_arr[ID_W-1:0];
                            r_sp       <= r_sp + c_CNT_W'(1);
                            r_next_arr <= r_next_arr + c_CMP_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    // Occupancy holds through DONE and clears on the way
                    // back to IDLE together with the other counters.
                    r_state    <= ST_IDLE;
                    r_done     <= 1'b0;
                    r_result   <= 1'b0;
                    r_n        <= '0;
                    r_k        <= '0;
                    r_sp       <= '0;
                    r_next_arr <= c_CMP_W'(1);
                    r_ovf      <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
